// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register memory with byte-strobe writes,
// fixed wait states, error responses for bad accesses, and a saturating error counter.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 48,
   parameter int WAIT_STATES = 2
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR,
   output logic [7:0]              err_count
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
   localparam logic [3:0]     WAIT_L  = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state_reg, state_next;
   logic [3:0]              cnt_reg, cnt_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    write_reg, write_next;
   logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
   logic [STRB_W-1:0]       strb_reg, strb_next;
   logic                    err_reg, err_next;
   logic                    pready_reg, pready_next;
   logic                    pslverr_reg, pslverr_next;
   logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
   logic [7:0]              err_count_reg;

   logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   wr_word;
   logic                    commit;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      write_next = write_reg;
      wdata_next = wdata_reg;
      strb_next  = strb_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            // PENABLE already high here means no setup phase was seen: accept it, but as an error
            if (PSEL) begin
               idx_next   = PADDR[ADDR_WIDTH-1:2];
               write_next = PWRITE;
               wdata_next = PWDATA;
               strb_next  = PSTRB;
               err_next   = (|PADDR[1:0]) || ({1'b0, PADDR[ADDR_WIDTH-1:2]} >= DEPTH_L) || PENABLE;
               cnt_next   = WAIT_L;
               state_next = (WAIT_L == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_next = IDLE;
            end else if (PENABLE) begin
               if (cnt_reg <= 4'd1) state_next = RESP;
               else                 cnt_next   = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read data is fetched on entry to RESP so that PRDATA can be a plain register
   assign rd_word      = mem_reg[idx_next];
   assign pready_next  = (state_next == RESP);
   assign pslverr_next = pready_next && err_next;
   assign prdata_next  = (pready_next && !write_next && !err_next) ? rd_word : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         write_reg     <= 1'b0;
         wdata_reg     <= '0;
         strb_reg      <= '0;
         err_reg       <= 1'b0;
         pready_reg    <= 1'b0;
         pslverr_reg   <= 1'b0;
         prdata_reg    <= '0;
         err_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         write_reg     <= write_next;
         wdata_reg     <= wdata_next;
         strb_reg      <= strb_next;
         err_reg       <= err_next;
         pready_reg    <= pready_next;
         pslverr_reg   <= pslverr_next;
         prdata_reg    <= prdata_next;
         if (pready_reg && pslverr_reg && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 8'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane
         assign wr_word[gi*8 +: 8] = strb_reg[gi] ? wdata_reg[gi*8 +: 8]
                                                  : mem_reg[idx_reg][gi*8 +: 8];
      end
   endgenerate

   // Writes land at the edge that closes the PREADY cycle; error transfers never get here
   assign commit = (state_reg == RESP) && write_reg && !err_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int w = 0; w < DEPTH; w++) mem_reg[w] <= '0;
      end else if (commit) begin
         mem_reg[idx_reg] <= wr_word;
      end
   end

   assign PREADY    = pready_reg;
   assign PRDATA    = prdata_reg;
   assign PSLVERR   = pslverr_reg;
   assign err_count = err_count_reg;

endmodule
